// File: rtl/projectile_hit_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : projectile_hit_gen_pkg
//  Description : Shared game-logic types and constants for the projectile
//                source. Holds the projectile FSM state type, the cat's
//                on-screen box (also used by the cat sprite drawer) and a
//                small helper that turns a signed coordinate into an
//                unsigned pixel position.
//  Revision    : 1.0 - initial release
// ============================================================================
package projectile_hit_gen_pkg;

  // Projectile life cycle. Values are fixed so that waveforms and any
  // debug taps decode the same way across builds.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLIGHT   = 3'd1,
    CHECK    = 3'd2,
    HIT      = 3'd3,
    MISS     = 3'd4,
    COOLDOWN = 3'd5
  } proj_state_t;

  // Cat bounding box on screen: left/top inclusive, right/bottom exclusive.
  localparam int CAT_X = 1;
  localparam int CAT_Y = 430;
  localparam int CAT_W = 157;
  localparam int CAT_H = 99;

  // Width of the signed internal position registers and of the on-screen
  // pixel coordinate presented to the sprite drawer.
  localparam int POS_W = 12;
  localparam int PIX_W = 11;
  localparam int VEL_W = 8;

  // Negative coordinates are off the left/top edge; present them as 0.
  function automatic logic [PIX_W-1:0] clamp_px(input logic signed [POS_W-1:0] v);
    return v[POS_W-1] ? '0 : v[PIX_W-1:0];
  endfunction

endpackage : projectile_hit_gen_pkg
`default_nettype wire

// File: rtl/projectile_hit_gen_point_in_box.sv
`default_nettype none
// ============================================================================
//  Module      : point_in_box
//  Description : Combinational test of a signed point against an axis-
//                aligned box. Left/top edges are inclusive, right/bottom
//                edges exclusive, so adjacent boxes never overlap.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_x       in   12  signed point x
//    i_y       in   12  signed point y
//    o_inside  out  1   1 when the point lies inside the box
// ============================================================================
module point_in_box
  import projectile_hit_gen_pkg::*;
#(
  parameter int BOX_X = CAT_X,
  parameter int BOX_Y = CAT_Y,
  parameter int BOX_W = CAT_W,
  parameter int BOX_H = CAT_H
) (
  input  logic signed [POS_W-1:0] i_x,
  input  logic signed [POS_W-1:0] i_y,
  output logic                    o_inside
);

  // Promote to int so the box bounds (which may exceed the point width
  // once added together) compare as plain signed integers.
  int w_x;
  int w_y;
  logic w_in_x;
  logic w_in_y;

  assign w_x = int'(i_x);
  assign w_y = int'(i_y);

  assign w_in_x = (w_x >= BOX_X) && (w_x < (BOX_X + BOX_W));
  assign w_in_y = (w_y >= BOX_Y) && (w_y < (BOX_Y + BOX_H));

  assign o_inside = w_in_x && w_in_y;

endmodule : point_in_box
`default_nettype wire

// File: rtl/projectile_hit_gen.sv
`default_nettype none
// ============================================================================
//  Module      : projectile_hit_gen
//  Description : Launches one projectile per fire request, advances it once
//                per frame (constant leftward vx, gravity on vy with a
//                downward speed cap), and tests it against the cat's box.
//                Emits a 1-cycle hit_cat pulse on contact or a 1-cycle miss
//                pulse when it leaves the screen, then waits a fixed number
//                of frames before accepting the next fire.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk          in   1   pixel clock
//    rst_n        in   1   asynchronous active-low reset
//    frame_tick   in   1   1-cycle pulse once per frame
//    fire         in   1   launch request, sampled only when idle
//    vx_in        in   6   horizontal speed magnitude (moves left)
//    vy_in        in   6   initial upward speed magnitude
//    hit_cat      out  1   1-cycle pulse on collision with the cat
//    miss         out  1   1-cycle pulse when the projectile leaves screen
//    proj_x       out  11  projectile x, 0 when negative
//    proj_y       out  11  projectile y, 0 when negative
//    proj_active  out  1   high while the projectile is in flight
//    busy         out  1   high in every state except idle
// ============================================================================
module projectile_hit_gen
  import projectile_hit_gen_pkg::*;
#(
  parameter int START_X         = 860,
  parameter int START_Y         = 430,
  parameter int TARGET_X        = CAT_X,
  parameter int TARGET_Y        = CAT_Y,
  parameter int TARGET_W        = CAT_W,
  parameter int TARGET_H        = CAT_H,
  parameter int GRAVITY         = 1,
  parameter int VY_MAX          = 63,
  parameter int SCREEN_H        = 768,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             fire,
  input  logic [5:0]       vx_in,
  input  logic [5:0]       vy_in,
  output logic             hit_cat,
  output logic             miss,
  output logic [PIX_W-1:0] proj_x,
  output logic [PIX_W-1:0] proj_y,
  output logic             proj_active,
  output logic             busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic signed [POS_W-1:0] c_START_X  = POS_W'(START_X);
  localparam logic signed [POS_W-1:0] c_START_Y  = POS_W'(START_Y);
  localparam logic signed [POS_W-1:0] c_SCREEN_H = POS_W'(SCREEN_H);
  // One extra bit on the vy update so vy + GRAVITY cannot wrap before
  // the saturation compare.
  localparam logic signed [VEL_W:0]   c_GRAVITY  = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   c_VY_MAX   = (VEL_W+1)'(VY_MAX);
  localparam int                      c_CNT_W    = (COOLDOWN_FRAMES > 1) ?
                                                   $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [c_CNT_W-1:0]      c_CNT_LAST = c_CNT_W'(COOLDOWN_FRAMES - 1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  proj_state_t              r_state;
  proj_state_t              w_state_nxt;

  logic signed [POS_W-1:0]  r_x;
  logic signed [POS_W-1:0]  r_y;
  logic signed [VEL_W-1:0]  r_vx;
  logic signed [VEL_W-1:0]  r_vy;
  logic [c_CNT_W-1:0]       r_cnt;
  logic [PIX_W-1:0]         r_proj_x;
  logic [PIX_W-1:0]         r_proj_y;

  // FSM-issued datapath strobes
  logic w_launch;
  logic w_move;
  logic w_cnt_clr;
  logic w_cnt_inc;

  // --------------------------------------------------------------------------
  // Kinematics (combinational next values)
  // --------------------------------------------------------------------------
  logic signed [POS_W-1:0]  w_x_sum;
  logic signed [POS_W-1:0]  w_y_sum;
  logic signed [VEL_W:0]    w_vy_inc;
  logic signed [VEL_W-1:0]  w_vy_nxt;
  logic signed [VEL_W-1:0]  w_vx_launch;
  logic signed [VEL_W-1:0]  w_vy_launch;
  logic                     w_inside;
  logic                     w_off_screen;

  // Velocities are sign-extended to position width before the add.
  assign w_x_sum = r_x + {{(POS_W-VEL_W){r_vx[VEL_W-1]}}, r_vx};
  assign w_y_sum = r_y + {{(POS_W-VEL_W){r_vy[VEL_W-1]}}, r_vy};

  // Gravity pulls vy toward positive (downward); cap at the terminal speed.
  assign w_vy_inc = {r_vy[VEL_W-1], r_vy} + c_GRAVITY;
  assign w_vy_nxt = (w_vy_inc > c_VY_MAX) ? c_VY_MAX[VEL_W-1:0] : w_vy_inc[VEL_W-1:0];

  // The cat sits to the left and the launch goes upward, so both launch
  // speeds are stored negated.
  assign w_vx_launch = 8'sd0 - $signed({2'b00, vx_in});
  assign w_vy_launch = 8'sd0 - $signed({2'b00, vy_in});

  // Only the left and bottom edges can be crossed in normal play; a
  // projectile above the screen will fall back.
  assign w_off_screen = (r_x < 12'sd0) || (r_y >= c_SCREEN_H);

  point_in_box #(
    .BOX_X (TARGET_X),
    .BOX_Y (TARGET_Y),
    .BOX_W (TARGET_W),
    .BOX_H (TARGET_H)
  ) u_box (
    .i_x      (r_x),
    .i_y      (r_y),
    .o_inside (w_inside)
  );

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state, datapath strobes and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_move      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    hit_cat     = 1'b0;
    miss        = 1'b0;
    proj_active = 1'b0;
    busy        = 1'b1;

    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        // A tick coinciding with the launch is not a move; the first
        // move comes on the next tick.
        if (fire) begin
          w_launch    = 1'b1;
          w_state_nxt = FLIGHT;
        end
      end

      FLIGHT: begin
        proj_active = 1'b1;
        if (frame_tick) begin
          w_move      = 1'b1;
          w_state_nxt = CHECK;
        end
      end

      CHECK: begin
        // Evaluates the position just written by the move; a hit takes
        // precedence over leaving the screen.
        proj_active = 1'b1;
        if (w_inside) begin
          w_state_nxt = HIT;
        end else if (w_off_screen) begin
          w_state_nxt = MISS;
        end else begin
          w_state_nxt = FLIGHT;
        end
      end

      HIT: begin
        hit_cat     = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = COOLDOWN;
      end

      MISS: begin
        miss        = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = COOLDOWN;
      end

      COOLDOWN: begin
        if (frame_tick) begin
          if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Kinematic registers and registered position outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= c_START_X;
      r_y      <= c_START_Y;
      r_vx     <= '0;
      r_vy     <= '0;
      r_proj_x <= '0;
      r_proj_y <= '0;
    end else if (w_launch) begin
      r_x      <= c_START_X;
      r_y      <= c_START_Y;
      r_vx     <= w_vx_launch;
      r_vy     <= w_vy_launch;
      r_proj_x <= clamp_px(c_START_X);
      r_proj_y <= clamp_px(c_START_Y);
    end else if (w_move) begin
      r_x      <= w_x_sum;
      r_y      <= w_y_sum;
      r_vy     <= w_vy_nxt;
      r_proj_x <= clamp_px(w_x_sum);
      r_proj_y <= clamp_px(w_y_sum);
    end
  end

  // --------------------------------------------------------------------------
  // Cooldown frame counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign proj_x = r_proj_x;
  assign proj_y = r_proj_y;

endmodule : projectile_hit_gen
`default_nettype wire

// File: tb/tb_projectile_hit_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_projectile_hit_gen
//  Description : Self-checking bench for projectile_hit_gen. A behavioural
//                trajectory model predicts every output each cycle from the
//                launch parameters and the frame ticks; hand-computed
//                trajectory results pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_projectile_hit_gen;

  localparam int FRAME = 20;   // clocks per frame tick

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        fire = 1'b0;
  logic [5:0]  vx_in = '0;
  logic [5:0]  vy_in = '0;
  logic        hit_cat;
  logic        miss;
  logic [10:0] proj_x;
  logic [10:0] proj_y;
  logic        proj_active;
  logic        busy;

  projectile_hit_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .fire        (fire),
    .vx_in       (vx_in),
    .vy_in       (vy_in),
    .hit_cat     (hit_cat),
    .miss        (miss),
    .proj_x      (proj_x),
    .proj_y      (proj_y),
    .proj_active (proj_active),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_ticks = 0;
  int last_tick_cyc = -100;
  bit tick_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame tick generator: one high cycle every FRAME clocks.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (tick_en && cnt == FRAME - 1) begin
        frame_tick    = 1'b1;
        last_tick_cyc = cyc;
        n_ticks++;
        cnt = 0;
      end else begin
        frame_tick = 1'b0;
        if (tick_en) cnt++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Behavioural model. Tracks the projectile as integers and predicts the
  // outputs for the cycle that starts at each clock edge, using cycle
  // stamps: the verdict pulse lands two cycles after the deciding tick, and
  // the cooldown only counts ticks after that pulse.
  // --------------------------------------------------------------------------
  int m_x, m_y, m_vx, m_vy;
  bit m_busy = 0, m_air = 0, m_hit = 0;
  int m_tick_ok = 0, m_pulse_at = -10, m_cool_left = 0;
  int m_frames = 0, m_last_frames = 0;
  int mk;
  bit exp_hit = 0, exp_miss = 0, exp_active = 0, exp_busy = 0;
  int exp_px = 0, exp_py = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_air = 0; m_pulse_at = -10;
      m_x = 860; m_y = 430; m_vx = 0; m_vy = 0;
      exp_hit = 0; exp_miss = 0; exp_active = 0; exp_busy = 0;
      exp_px = 0; exp_py = 0;
    end else begin
      mk = cyc;
      if (!m_busy) begin
        if (fire) begin
          m_x = 860; m_y = 430;
          m_vx = -int'(vx_in); m_vy = -int'(vy_in);
          m_busy = 1; m_air = 1; m_tick_ok = mk + 1;
          m_frames = 0; m_pulse_at = -10;
          exp_px = 860; exp_py = 430;
        end
      end else if (m_air) begin
        if (frame_tick && mk >= m_tick_ok) begin
          m_frames++;
          m_x = m_x + m_vx;
          m_y = m_y + m_vy;
          m_vy = (m_vy + 1 > 63) ? 63 : m_vy + 1;
          exp_px = (m_x < 0) ? 0 : m_x;
          exp_py = (m_y < 0) ? 0 : m_y;
          if (m_x >= 1 && m_x < 158 && m_y >= 430 && m_y < 529) begin
            m_air = 0; m_hit = 1; m_pulse_at = mk + 2;
            m_cool_left = 30; m_last_frames = m_frames;
          end else if (m_x < 0 || m_y >= 768) begin
            m_air = 0; m_hit = 0; m_pulse_at = mk + 2;
            m_cool_left = 30; m_last_frames = m_frames;
          end else begin
            m_tick_ok = mk + 2;
          end
        end
      end else begin
        if (frame_tick && mk > m_pulse_at) begin
          m_cool_left--;
          if (m_cool_left == 0) m_busy = 0;
        end
      end
      exp_busy   = m_busy;
      exp_active = m_air || (m_busy && (mk + 1) < m_pulse_at);
      exp_hit    = m_busy && (mk + 1 == m_pulse_at) && m_hit;
      exp_miss   = m_busy && (mk + 1 == m_pulse_at) && !m_hit;
    end
  end

  // --------------------------------------------------------------------------
  // Compare process: every cycle, mid-cycle.
  // --------------------------------------------------------------------------
  bit pulse_seen = 0, pulse_hit = 0;
  int pulse_cyc = 0, pulse_tick_cyc = 0, pulse_px = 0, pulse_py = 0;
  int pulse_nticks = 0, n_pulses = 0;
  int prev_py = 0, max_dy = 0;
  bit prev_active = 0;

  always @(negedge clk) begin
    chk("hit_cat",     int'(hit_cat),     int'(exp_hit));
    chk("miss",        int'(miss),        int'(exp_miss));
    chk("proj_active", int'(proj_active), int'(exp_active));
    chk("busy",        int'(busy),        int'(exp_busy));
    chk("proj_x",      int'(proj_x),      exp_px);
    chk("proj_y",      int'(proj_y),      exp_py);
    if (hit_cat || miss) begin
      pulse_seen     = 1;
      pulse_hit      = hit_cat;
      pulse_cyc      = cyc;
      pulse_tick_cyc = last_tick_cyc;
      pulse_px       = int'(proj_x);
      pulse_py       = int'(proj_y);
      pulse_nticks   = n_ticks;
      n_pulses++;
    end
    if (proj_active && prev_active && int'(proj_y) - prev_py > max_dy)
      max_dy = int'(proj_y) - prev_py;
    prev_py     = int'(proj_y);
    prev_active = proj_active;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic launch(input int vx, input int vy);
    @(negedge clk);
    pulse_seen = 0;
    vx_in = 6'(vx);
    vy_in = 6'(vy);
    fire  = 1'b1;
    @(negedge clk);
    fire  = 1'b0;
  endtask

  task automatic wait_pulse(input int max_frames);
    for (int i = 0; i < max_frames * FRAME && !pulse_seen; i++) @(negedge clk);
    chk("pulse_within_budget", int'(pulse_seen), 1);
  endtask

  task automatic wait_idle(input int max_frames);
    for (int i = 0; i < max_frames * FRAME && busy; i++) @(negedge clk);
    chk("idle_within_budget", int'(busy), 0);
  endtask

  task automatic check_outcome(input string tag, input int is_hit, input int frames,
                               input int px, input int py);
    chk({tag, "_kind"},    int'(pulse_hit), is_hit);
    chk({tag, "_frame"},   m_last_frames, frames);
    chk({tag, "_x"},       pulse_px, px);
    chk({tag, "_y"},       pulse_py, py);
    chk({tag, "_latency"}, pulse_cyc - pulse_tick_cyc, 2);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int n0;

    // Reset, then ten idle frames with no pulses.
    repeat (3) @(negedge clk);
    chk("rst_busy",   int'(busy), 0);
    chk("rst_proj_x", int'(proj_x), 0);
    chk("rst_proj_y", int'(proj_y), 0);
    rst_n   = 1'b1;
    tick_en = 1'b1;
    repeat (10 * FRAME) @(negedge clk);
    chk("idle_pulses", n_pulses, 0);

    // Hit: x = 860-20n, y = 430-18n+n(n-1)/2 -> first in box at n=37 (120,430).
    launch(20, 18);
    wait_pulse(60);
    check_outcome("hit", 1, 37, 120, 430);

    // Cooldown with fire held: exactly 30 ticks busy, then relaunch.
    fire = 1'b1;
    for (int i = 0; i < 40 * FRAME && busy; i++) @(negedge clk);
    chk("cooldown_ticks", n_ticks - pulse_nticks, 30);
    @(negedge clk);
    chk("relaunch_busy",   int'(busy), 1);
    chk("relaunch_active", int'(proj_active), 1);
    chk("relaunch_x",      int'(proj_x), 860);
    fire = 1'b0;
    pulse_seen = 0;
    wait_pulse(60);
    check_outcome("rehit", 1, 37, 120, 430);
    wait_idle(40);

    // Straight drop: y = 430+n(n-1)/2 crosses 768 at n=27 (y=781).
    launch(0, 0);
    wait_pulse(60);
    check_outcome("drop", 0, 27, 860, 781);
    wait_idle(40);

    // Lob over the cat: vy_in=10 passes above... below the box, misses at n=39.
    launch(20, 10);
    wait_pulse(60);
    check_outcome("lob", 0, 39, 80, 781);
    wait_idle(40);

    // Reset during flight at frame 5.
    launch(20, 18);
    for (int i = 0; i < 10 * FRAME && m_frames < 5; i++) @(negedge clk);
    chk("midflight_reached", m_frames, 5);
    n0 = n_pulses;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy",   int'(busy), 0);
    chk("midrst_active", int'(proj_active), 0);
    rst_n = 1'b1;
    repeat (10 * FRAME) @(negedge clk);
    chk("midrst_pulses", n_pulses, n0);

    // Saturation: vy from -63 reaches the 63 cap at frame 127; miss at 133, y=808.
    max_dy = 0;
    launch(0, 63);
    wait_pulse(150);
    check_outcome("sat", 0, 133, 860, 808);
    chk("sat_max_dy", max_dy, 63);
    wait_idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_projectile_hit_gen
`default_nettype wire
